victim_cache_ctrl_v2: RTL and testbench
=======================================

Name: victim_cache_ctrl_v2

Overview:
Second-generation fully associative victim cache between the direct-mapped L1 and memory. Compared with the first generation, it adds a parametrised write-back buffer so a dirty victim no longer blocks an install, and install backpressure. It also adds a configurable replacement mode, in-place merge of duplicate tags, a full flush sequence and an occupancy output. The probe, evict and memory interfaces keep first-generation semantics: probe has priority, a probe hit invalidates the entry, and lines are written back only when valid and dirty.

Parameters:
TAG_WIDTH, 20, line tag width in bits
LINE_BYTES, 16, bytes per line
NUM_WAYS, 4, number of VC entries (power of two, minimum 2)
WB_DEPTH, 2, write-back buffer entries (minimum 1)
REPL_MODE, 0, victim selection: 0 = strict FIFO pointer; 1 = lowest-index invalid way first, else FIFO pointer

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
probe_valid  in  1  probe request, 1-cycle pulse
probe_tag  in  TAG_WIDTH  tag to look up
probe_ready  out  1  1-cycle pulse; result valid
probe_hit  out  1  hit flag, valid with probe_ready
probe_line  out  LINE_BYTES*8  hit data, zero on miss
probe_dirty  out  1  dirty bit of the hit entry
evict_valid  in  1  L1 victim offered
evict_ready  out  1  pending slot free; evict accepted when valid && ready
evict_tag  in  TAG_WIDTH  victim tag
evict_line  in  LINE_BYTES*8  victim data
evict_dirty  in  1  victim dirty
evict_ack  out  1  1-cycle pulse; install complete
flush_req  in  1  flush request pulse
flush_done  out  1  1-cycle pulse; VC empty and WB drained
mem_req  out  1  write-back request, held while WB non-empty
mem_req_write  out  1  high whenever mem_req is high
mem_req_tag  out  TAG_WIDTH  WB head tag
mem_req_wdata  out  LINE_BYTES*8  WB head data
mem_resp_valid  in  1  memory accepted the head; pop
occupancy  out  $clog2(NUM_WAYS+1)  count of valid entries

Behaviour:
- Reset (async, rst_n low): all entries invalid, FIFO pointer 0, WB empty, pending evict empty. All outputs 0 except evict_ready=1. A reset mid-operation abandons any operation and loses WB contents.
- FSM states: IDLE, LOOKUP, RESP, INSTALL, WB_STALL, FLUSH_WALK, FLUSH_DRAIN.
- IDLE arbitration, sampled each cycle, in priority order: probe_valid, then flush_req, then pending evict.
- Probe timing: probe_valid sampled at edge N. LOOKUP compares the registered tag at N+1. probe_ready pulses during cycle N+2 with registered hit/line/dirty. On a hit, the entry is invalidated at the N+2 edge, occupancy decrements and the FIFO pointer is unchanged.
- A probe_valid arriving outside IDLE is ignored. The L1 waits for probe_ready before issuing the next probe.
- Evict capture:
  - An accepted evict loads the pending register in any state and drops evict_ready to 0.
  - evict_ready returns to 1 the cycle after evict_ack.
- Install:
  - Duplicate tag (matches a valid way): overwrite that way, new dirty = old dirty OR evict_dirty, no victim, pointer unchanged.
  - Otherwise select a victim way per REPL_MODE.
  - If the victim is valid and dirty and the WB is full, enter WB_STALL until a pop, then continue.
  - A valid and dirty victim is pushed to the WB; a clean or invalid victim is dropped silently.
  - The new line is written and the pointer advances (mod NUM_WAYS) when the FIFO pointer way was used. evict_ack pulses the cycle after the write.
- WB drain runs independently of the FSM, oldest first.
  - mem_req is high iff WB is non-empty; tag/wdata present the head.
  - mem_resp_valid pops the head. mem_resp_valid with mem_req low is ignored.
  - Push and pop in the same cycle are both honoured.
- Flush:
  - FLUSH_WALK visits ways 0..NUM_WAYS-1, one per cycle. Each valid dirty way is pushed to the WB, stalling on WB full. Every way is invalidated.
  - FLUSH_DRAIN waits for WB empty, then flush_done pulses and the FSM returns to IDLE. The pointer resets to 0.
  - A pending evict waits until after flush_done.
- occupancy updates the cycle after the change. It never exceeds NUM_WAYS and never underflows.

Optional Feature:
VC_WB_FWD_EN:
- Defined: LOOKUP also searches valid WB entries, with a VC hit taking precedence. A WB hit returns probe_hit=1 with that data and probe_dirty=0. The WB entry stays queued and still writes back.
- Undefined: WB-resident lines always miss.

Test Plan:
- Install tag 1 clean, probe 1 -> probe_ready 2 cycles after probe_valid, hit=1, line=1, dirty=0; re-probe 1 -> hit=0, occupancy 0.
- Fill tags 10 (dirty) and 11..13 clean, install 99 with mem_resp withheld -> evict_ack without waiting for memory; mem_req=1, mem_req_tag=10; mem_resp_valid pops the entry and mem_req drops.
- WB_DEPTH=1: two dirty victims with memory stalled -> second install holds in WB_STALL, evict_ready=0 until pop, then evict_ack.
- Install tag 50 dirty=0, then tag 50 dirty=1 -> occupancy unchanged at 1; probe 50 -> hit, dirty=1.
- REPL_MODE=1: fill 4 entries, probe-hit way 2, install 77 -> 77 lands in way 2 and no clean line is lost; probes of all other tags hit.
- Tags 1 (dirty), 2 (clean) and 3 (dirty) resident, flush_req -> mem writes for tag 1 then tag 3; flush_done after the last mem_resp_valid; occupancy 0. With VC_WB_FWD_EN, a probe of tag 3 while still queued -> hit, dirty=0.

Source files
------------

// File: rtl/victim_cache_ctrl_v2.sv
// Fully associative victim cache with a write-back buffer, duplicate-tag merge and flush.
// Optional define VC_WB_FWD_EN lets probes hit lines still queued in the write-back buffer.
module victim_cache_ctrl_v2 #(
  parameter int unsigned TAG_WIDTH  = 20,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned WB_DEPTH   = 2,
  parameter int unsigned REPL_MODE  = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            probe_valid,
  input  logic [TAG_WIDTH-1:0]            probe_tag,
  output logic                            probe_ready,
  output logic                            probe_hit,
  output logic [LINE_BYTES*8-1:0]         probe_line,
  output logic                            probe_dirty,
  input  logic                            evict_valid,
  output logic                            evict_ready,
  input  logic [TAG_WIDTH-1:0]            evict_tag,
  input  logic [LINE_BYTES*8-1:0]         evict_line,
  input  logic                            evict_dirty,
  output logic                            evict_ack,
  input  logic                            flush_req,
  output logic                            flush_done,
  output logic                            mem_req,
  output logic                            mem_req_write,
  output logic [TAG_WIDTH-1:0]            mem_req_tag,
  output logic [LINE_BYTES*8-1:0]         mem_req_wdata,
  input  logic                            mem_resp_valid,
  output logic [$clog2(NUM_WAYS+1)-1:0]   occupancy
);

  localparam int unsigned LineW  = LINE_BYTES * 8;
  localparam int unsigned WayW   = $clog2(NUM_WAYS);
  localparam int unsigned OccW   = $clog2(NUM_WAYS + 1);
  localparam int unsigned WbIdxW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned WbCntW = $clog2(WB_DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle, StLookup, StResp, StInstall, StWbStall, StFlushWalk, StFlushDrain
  } state_e;

  state_e state_q, state_d;

  logic [NUM_WAYS-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_WIDTH-1:0] tag_q  [NUM_WAYS];
  logic [LineW-1:0]     line_q [NUM_WAYS];
  logic [WayW-1:0]      ptr_q, ptr_d, walk_q, walk_d;
  logic [OccW-1:0]      occ_q, occ_d;

  logic [TAG_WIDTH-1:0] ptag_q, ptag_d;
  logic                 resp_hit_q, resp_hit_d, resp_dirty_q, resp_dirty_d;
  logic                 resp_vc_q, resp_vc_d;
  logic [LineW-1:0]     resp_line_q, resp_line_d;
  logic [WayW-1:0]      resp_way_q, resp_way_d;
  logic                 ack_q, ack_d, done_q, done_d;

  logic                 pend_valid_q, pend_valid_d, pend_dirty_q, pend_dirty_d;
  logic [TAG_WIDTH-1:0] pend_tag_q, pend_tag_d;
  logic [LineW-1:0]     pend_line_q, pend_line_d;

  logic [TAG_WIDTH-1:0] wb_tag_q  [WB_DEPTH];
  logic [LineW-1:0]     wb_data_q [WB_DEPTH];
  logic [WbIdxW-1:0]    wb_rd_q, wb_rd_d, wb_wr_q, wb_wr_d;
  logic [WbCntW-1:0]    wb_cnt_q, wb_cnt_d;
  logic                 wb_push, wb_pop, wb_full, can_push;
  logic [TAG_WIDTH-1:0] wb_push_tag;
  logic [LineW-1:0]     wb_push_data;

  logic                 inst_we;
  logic [WayW-1:0]      inst_way;
  logic                 vc_hit, dup_hit, inv_found, need_push, flush_wb;
  logic [WayW-1:0]      vc_way, dup_way, inv_way, vict_way;
  logic                 wb_hit;
  logic [LineW-1:0]     wb_hit_data;

  function automatic logic [WbIdxW-1:0] wb_next(logic [WbIdxW-1:0] p);
    return (p == WbIdxW'(WB_DEPTH - 1)) ? '0 : p + WbIdxW'(1);
  endfunction

  function automatic logic [OccW-1:0] popcnt(logic [NUM_WAYS-1:0] v);
    logic [OccW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_WAYS; i++) c = c + OccW'(v[i]);
    return c;
  endfunction

  // Downward scans leave the lowest matching index.
  always_comb begin
    vc_hit    = 1'b0;
    vc_way    = '0;
    dup_hit   = 1'b0;
    dup_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == ptag_q)) begin
        vc_hit = 1'b1;
        vc_way = WayW'(i);
      end
      if (valid_q[i] && (tag_q[i] == pend_tag_q)) begin
        dup_hit = 1'b1;
        dup_way = WayW'(i);
      end
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_way   = WayW'(i);
      end
    end
  end

`ifdef VC_WB_FWD_EN
  // Scan head to tail so the youngest queued copy of a tag wins.
  always_comb begin
    logic [WbIdxW-1:0] idx;
    wb_hit      = 1'b0;
    wb_hit_data = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = WbIdxW'((int'(wb_rd_q) + k) % WB_DEPTH);
      if ((k < int'(wb_cnt_q)) && (wb_tag_q[idx] == ptag_q)) begin
        wb_hit      = 1'b1;
        wb_hit_data = wb_data_q[idx];
      end
    end
  end
`else
  assign wb_hit      = 1'b0;
  assign wb_hit_data = '0;
`endif

  assign vict_way  = ((REPL_MODE == 1) && inv_found) ? inv_way : ptr_q;
  assign need_push = !dup_hit && valid_q[vict_way] && dirty_q[vict_way];
  assign flush_wb  = valid_q[walk_q] && dirty_q[walk_q];
  assign wb_pop    = mem_resp_valid && (wb_cnt_q != '0);
  assign wb_full   = (wb_cnt_q == WbCntW'(WB_DEPTH));
  assign can_push  = !wb_full || wb_pop;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    ptr_d        = ptr_q;
    walk_d       = walk_q;
    ptag_d       = ptag_q;
    resp_hit_d   = resp_hit_q;
    resp_line_d  = resp_line_q;
    resp_dirty_d = resp_dirty_q;
    resp_vc_d    = resp_vc_q;
    resp_way_d   = resp_way_q;
    ack_d        = 1'b0;
    done_d       = 1'b0;
    wb_push      = 1'b0;
    wb_push_tag  = '0;
    wb_push_data = '0;
    inst_we      = 1'b0;
    inst_way     = '0;
    unique case (state_q)
      StIdle: begin
        if (probe_valid) begin
          ptag_d  = probe_tag;
          state_d = StLookup;
        end else if (flush_req) begin
          walk_d  = '0;
          state_d = StFlushWalk;
        end else if (pend_valid_q && !ack_q) begin
          state_d = StInstall;
        end
      end
      StLookup: begin
        resp_hit_d   = vc_hit | wb_hit;
        resp_line_d  = vc_hit ? line_q[vc_way] : (wb_hit ? wb_hit_data : '0);
        resp_dirty_d = vc_hit & dirty_q[vc_way];
        resp_vc_d    = vc_hit;
        resp_way_d   = vc_way;
        state_d      = StResp;
      end
      StResp: begin
        if (resp_vc_q) begin
          valid_d[resp_way_q] = 1'b0;
          dirty_d[resp_way_q] = 1'b0;
        end
        state_d = StIdle;
      end
      StInstall, StWbStall: begin
        if (dup_hit) begin
          inst_we          = 1'b1;
          inst_way         = dup_way;
          dirty_d[dup_way] = dirty_q[dup_way] | pend_dirty_q;
          ack_d            = 1'b1;
          state_d          = StIdle;
        end else if (need_push && !can_push) begin
          state_d = StWbStall;
        end else begin
          wb_push           = need_push;
          wb_push_tag       = tag_q[vict_way];
          wb_push_data      = line_q[vict_way];
          inst_we           = 1'b1;
          inst_way          = vict_way;
          valid_d[vict_way] = 1'b1;
          dirty_d[vict_way] = pend_dirty_q;
          if (vict_way == ptr_q) ptr_d = ptr_q + WayW'(1);
          ack_d             = 1'b1;
          state_d           = StIdle;
        end
      end
      StFlushWalk: begin
        if (!flush_wb || can_push) begin
          wb_push         = flush_wb;
          wb_push_tag     = tag_q[walk_q];
          wb_push_data    = line_q[walk_q];
          valid_d[walk_q] = 1'b0;
          dirty_d[walk_q] = 1'b0;
          if (walk_q == WayW'(NUM_WAYS - 1)) state_d = StFlushDrain;
          else walk_d = walk_q + WayW'(1);
        end
      end
      StFlushDrain: begin
        if (wb_cnt_q == '0) begin
          done_d  = 1'b1;
          ptr_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending slot frees one cycle after the ack so evict_ready rises after evict_ack.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_tag_d   = pend_tag_q;
    pend_line_d  = pend_line_q;
    pend_dirty_d = pend_dirty_q;
    if (ack_q) pend_valid_d = 1'b0;
    if (evict_valid && evict_ready) begin
      pend_valid_d = 1'b1;
      pend_tag_d   = evict_tag;
      pend_line_d  = evict_line;
      pend_dirty_d = evict_dirty;
    end
  end

  always_comb begin
    wb_rd_d  = wb_pop ? wb_next(wb_rd_q) : wb_rd_q;
    wb_wr_d  = wb_push ? wb_next(wb_wr_q) : wb_wr_q;
    wb_cnt_d = wb_cnt_q + WbCntW'(wb_push) - WbCntW'(wb_pop);
    occ_d    = popcnt(valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      dirty_q      <= '0;
      ptr_q        <= '0;
      walk_q       <= '0;
      occ_q        <= '0;
      ptag_q       <= '0;
      resp_hit_q   <= 1'b0;
      resp_line_q  <= '0;
      resp_dirty_q <= 1'b0;
      resp_vc_q    <= 1'b0;
      resp_way_q   <= '0;
      ack_q        <= 1'b0;
      done_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_tag_q   <= '0;
      pend_line_q  <= '0;
      pend_dirty_q <= 1'b0;
      wb_rd_q      <= '0;
      wb_wr_q      <= '0;
      wb_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      ptr_q        <= ptr_d;
      walk_q       <= walk_d;
      occ_q        <= occ_d;
      ptag_q       <= ptag_d;
      resp_hit_q   <= resp_hit_d;
      resp_line_q  <= resp_line_d;
      resp_dirty_q <= resp_dirty_d;
      resp_vc_q    <= resp_vc_d;
      resp_way_q   <= resp_way_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      pend_valid_q <= pend_valid_d;
      pend_tag_q   <= pend_tag_d;
      pend_line_q  <= pend_line_d;
      pend_dirty_q <= pend_dirty_d;
      wb_rd_q      <= wb_rd_d;
      wb_wr_q      <= wb_wr_d;
      wb_cnt_q     <= wb_cnt_d;
    end
  end

  // Data arrays are qualified by valid bits and the WB count, so they need no reset.
  always_ff @(posedge clk) begin
    if (inst_we) begin
      tag_q[inst_way]  <= pend_tag_q;
      line_q[inst_way] <= pend_line_q;
    end
    if (wb_push) begin
      wb_tag_q[wb_wr_q]  <= wb_push_tag;
      wb_data_q[wb_wr_q] <= wb_push_data;
    end
  end

  assign probe_ready   = (state_q == StResp);
  assign probe_hit     = resp_hit_q;
  assign probe_line    = resp_line_q;
  assign probe_dirty   = resp_dirty_q;
  assign evict_ready   = !pend_valid_q;
  assign evict_ack     = ack_q;
  assign flush_done    = done_q;
  assign mem_req       = (wb_cnt_q != '0);
  assign mem_req_write = mem_req;
  assign mem_req_tag   = mem_req ? wb_tag_q[wb_rd_q] : '0;
  assign mem_req_wdata = mem_req ? wb_data_q[wb_rd_q] : '0;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_victim_cache_ctrl_v2.sv
// Scoreboard bench: instance 0 uses default parameters, instance 1 uses WB_DEPTH=1, REPL_MODE=1.
module tb_victim_cache_ctrl_v2;
  localparam int TW = 20;
  localparam int LW = 128;
  localparam int OW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic          pv [2], pr [2], ph [2], pd [2];
  logic [TW-1:0] pt [2];
  logic [LW-1:0] pl [2];
  logic          evv [2], evr [2], evd [2], eva [2];
  logic [TW-1:0] evt [2];
  logic [LW-1:0] evl [2];
  logic          fr [2], fd [2];
  logic          mq [2], mw [2], mrv [2];
  logic [TW-1:0] mt [2];
  logic [LW-1:0] mdat [2];
  logic [OW-1:0] occ [2];
  bit            hold [2];

  int n_chk = 0;
  int n_err = 0;
  bit sim_done = 1'b0;

  typedef struct {
    int            d;
    logic          hit;
    logic [LW-1:0] line;
    logic          dirty;
    int            cyc;
  } pexp_t;

  typedef struct {
    int            d;
    logic [TW-1:0] tag;
    logic [LW-1:0] line;
  } mexp_t;

  pexp_t pq [$];
  mexp_t mexp [$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    victim_cache_ctrl_v2 #(
      .TAG_WIDTH (TW),
      .LINE_BYTES(16),
      .NUM_WAYS  (4),
      .WB_DEPTH  ((g == 0) ? 2 : 1),
      .REPL_MODE ((g == 0) ? 0 : 1)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .probe_valid   (pv[g]),
      .probe_tag     (pt[g]),
      .probe_ready   (pr[g]),
      .probe_hit     (ph[g]),
      .probe_line    (pl[g]),
      .probe_dirty   (pd[g]),
      .evict_valid   (evv[g]),
      .evict_ready   (evr[g]),
      .evict_tag     (evt[g]),
      .evict_line    (evl[g]),
      .evict_dirty   (evd[g]),
      .evict_ack     (eva[g]),
      .flush_req     (fr[g]),
      .flush_done    (fd[g]),
      .mem_req       (mq[g]),
      .mem_req_write (mw[g]),
      .mem_req_tag   (mt[g]),
      .mem_req_wdata (mdat[g]),
      .mem_resp_valid(mrv[g]),
      .occupancy     (occ[g])
    );
  end

  function automatic logic [LW-1:0] mk_line(logic [TW-1:0] t);
    return {4{12'hABC, t}};
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pv[d] = 1'b0; pt[d] = '0; evv[d] = 1'b0; evt[d] = '0;
      evl[d] = '0; evd[d] = 1'b0; fr[d] = 1'b0; hold[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic evict_issue(input int d, input logic [TW-1:0] t, input logic [LW-1:0] l,
                             input logic dy);
    @(negedge clk);
    evv[d] = 1'b1; evt[d] = t; evl[d] = l; evd[d] = dy;
    for (int n = 0; n < 100 && !evr[d]; n++) @(negedge clk);
    chk($sformatf("evict_ready%0d_tag%0d", d, t), evr[d], 1'b1);
    @(negedge clk);
    evv[d] = 1'b0;
  endtask

  task automatic wait_ack(input int d, input int bound);
    logic got;
    got = 1'b0;
    for (int n = 0; n < bound; n++) begin
      if (eva[d]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("evict_ack%0d", d), got, 1'b1);
  endtask

  task automatic install(input int d, input logic [TW-1:0] t, input logic [LW-1:0] l,
                         input logic dy);
    evict_issue(d, t, l, dy);
    wait_ack(d, 20);
    @(negedge clk);
  endtask

  task automatic probe(input int d, input logic [TW-1:0] t, input logic hit,
                       input logic [LW-1:0] line, input logic dirty);
    pexp_t p;
    @(negedge clk);
    pv[d] = 1'b1; pt[d] = t;
    p.d = d; p.hit = hit; p.line = line; p.dirty = dirty; p.cyc = cyc + 2;
    pq.push_back(p);
    @(negedge clk);
    pv[d] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic exp_mem(input int d, input logic [TW-1:0] t);
    mexp_t m;
    m.d = d; m.tag = t; m.line = mk_line(t);
    mexp.push_back(m);
  endtask

  // Probe monitor plus memory responder; accepts the WB head whenever not held.
  task automatic monitor_step();
    pexp_t p;
    mexp_t m;
    for (int d = 0; d < 2; d++) begin
      if (pr[d]) begin
        if (pq.size() == 0) begin
          chk($sformatf("probe_unexpected%0d", d), 1'b1, 1'b0);
        end else begin
          p = pq.pop_front();
          chk("probe_dut", d, p.d);
          chk("probe_latency", cyc, p.cyc);
          chk("probe_hit", ph[d], p.hit);
          chk("probe_line", pl[d], p.line);
          chk("probe_dirty", pd[d], p.dirty);
        end
      end
      mrv[d] = 1'b0;
      if (rst_n && mq[d] && !hold[d]) begin
        chk("mem_req_write", mw[d], 1'b1);
        if (mexp.size() == 0) begin
          chk($sformatf("mem_unexpected%0d_tag", d), mt[d], '1);
        end else begin
          m = mexp.pop_front();
          chk("mem_dut", d, m.d);
          chk("mem_tag", mt[d], m.tag);
          chk("mem_data", mdat[d], m.line);
        end
        mrv[d] = 1'b1;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      pv[d] = 1'b0; pt[d] = '0; evv[d] = 1'b0; evt[d] = '0; evl[d] = '0;
      evd[d] = 1'b0; fr[d] = 1'b0; mrv[d] = 1'b0; hold[d] = 1'b0;
    end
    fork
      begin : stim
        logic seen;
        do_reset();
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("rst_probe_ready%0d", d), pr[d], 1'b0);
          chk($sformatf("rst_probe_hit%0d", d), ph[d], 1'b0);
          chk($sformatf("rst_probe_line%0d", d), pl[d], '0);
          chk($sformatf("rst_evict_ready%0d", d), evr[d], 1'b1);
          chk($sformatf("rst_evict_ack%0d", d), eva[d], 1'b0);
          chk($sformatf("rst_flush_done%0d", d), fd[d], 1'b0);
          chk($sformatf("rst_mem_req%0d", d), mq[d], 1'b0);
          chk($sformatf("rst_mem_tag%0d", d), mt[d], '0);
          chk($sformatf("rst_occupancy%0d", d), occ[d], '0);
        end

        // Basic install, probe hit, then miss after invalidation.
        install(0, 1, mk_line(1), 1'b0);
        chk("t1_occ1", occ[0], 3'd1);
        probe(0, 1, 1'b1, mk_line(1), 1'b0);
        chk("t1_occ0", occ[0], 3'd0);
        probe(0, 1, 1'b0, '0, 1'b0);

        // Dirty victim goes to WB without waiting for memory.
        do_reset();
        hold[0] = 1'b1;
        install(0, 10, mk_line(10), 1'b1);
        install(0, 11, mk_line(11), 1'b0);
        install(0, 12, mk_line(12), 1'b0);
        install(0, 13, mk_line(13), 1'b0);
        chk("t2_occ4", occ[0], 3'd4);
        exp_mem(0, 10);
        install(0, 99, mk_line(99), 1'b0);
        chk("t2_mem_req", mq[0], 1'b1);
        chk("t2_mem_tag", mt[0], 20'd10);
        chk("t2_occ_after", occ[0], 3'd4);
`ifdef VC_WB_FWD_EN
        probe(0, 10, 1'b1, mk_line(10), 1'b0);
`else
        probe(0, 10, 1'b0, '0, 1'b0);
`endif
        probe(0, 99, 1'b1, mk_line(99), 1'b0);
        chk("t2_occ3", occ[0], 3'd3);
        hold[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_mem_req_drop", mq[0], 1'b0);
        chk("t2_mem_drained", mexp.size(), 0);

        // WB_DEPTH=1: second dirty victim stalls until memory pops.
        do_reset();
        hold[1] = 1'b1;
        install(1, 20, mk_line(20), 1'b1);
        install(1, 21, mk_line(21), 1'b1);
        install(1, 22, mk_line(22), 1'b0);
        install(1, 23, mk_line(23), 1'b0);
        exp_mem(1, 20);
        install(1, 24, mk_line(24), 1'b0);
        exp_mem(1, 21);
        evict_issue(1, 25, mk_line(25), 1'b0);
        seen = 1'b0;
        repeat (6) begin
          if (eva[1]) seen = 1'b1;
          @(negedge clk);
        end
        chk("t3_stall_no_ack", seen, 1'b0);
        chk("t3_stall_evr", evr[1], 1'b0);
        hold[1] = 1'b0;
        wait_ack(1, 20);
        @(negedge clk);
        chk("t3_evr_back", evr[1], 1'b1);
        repeat (3) @(negedge clk);
        chk("t3_mem_idle", mq[1], 1'b0);
        chk("t3_mem_drained", mexp.size(), 0);
        probe(1, 25, 1'b1, mk_line(25), 1'b0);

        // Duplicate tag merges in place and ORs dirty.
        do_reset();
        install(0, 50, mk_line(50), 1'b0);
        chk("t4_occ_first", occ[0], 3'd1);
        install(0, 50, ~mk_line(50), 1'b1);
        chk("t4_occ_merge", occ[0], 3'd1);
        probe(0, 50, 1'b1, ~mk_line(50), 1'b1);
        chk("t4_occ_empty", occ[0], 3'd0);

        // REPL_MODE=1 reuses the hole left by a probe hit.
        do_reset();
        install(1, 30, mk_line(30), 1'b0);
        install(1, 31, mk_line(31), 1'b0);
        install(1, 32, mk_line(32), 1'b0);
        install(1, 33, mk_line(33), 1'b0);
        probe(1, 32, 1'b1, mk_line(32), 1'b0);
        chk("t5_occ3", occ[1], 3'd3);
        install(1, 77, mk_line(77), 1'b0);
        chk("t5_occ4", occ[1], 3'd4);
        probe(1, 30, 1'b1, mk_line(30), 1'b0);
        probe(1, 31, 1'b1, mk_line(31), 1'b0);
        probe(1, 33, 1'b1, mk_line(33), 1'b0);
        probe(1, 77, 1'b1, mk_line(77), 1'b0);

        // Flush writes back dirty ways in way order, done after WB drains.
        do_reset();
        hold[0] = 1'b1;
        install(0, 1, mk_line(1), 1'b1);
        install(0, 2, mk_line(2), 1'b0);
        install(0, 3, mk_line(3), 1'b1);
        exp_mem(0, 1);
        exp_mem(0, 3);
        @(negedge clk);
        fr[0] = 1'b1;
        @(negedge clk);
        fr[0] = 1'b0;
        seen = 1'b0;
        repeat (8) begin
          if (fd[0]) seen = 1'b1;
          @(negedge clk);
        end
        chk("t6_no_early_done", seen, 1'b0);
        chk("t6_mem_req_held", mq[0], 1'b1);
        hold[0] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
          if (fd[0]) begin
            seen = 1'b1;
            break;
          end
          @(negedge clk);
        end
        chk("t6_flush_done", seen, 1'b1);
        chk("t6_wb_written_first", mexp.size(), 0);
        chk("t6_occ0", occ[0], 3'd0);
        chk("t6_mem_idle", mq[0], 1'b0);
        probe(0, 3, 1'b0, '0, 1'b0);

        repeat (4) @(negedge clk);
        chk("end_probe_queue", pq.size(), 0);
        chk("end_mem_queue", mexp.size(), 0);
        sim_done = 1'b1;
      end
      begin : mon
        while (!sim_done) begin
          @(negedge clk);
          monitor_step();
        end
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
